// File: rtl/vm_pkg.sv
// Shared types for the vending machine controller/datapath pair.
package vm_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WAIT = 2'd1,
        ADD  = 2'd2,
        DISP = 2'd3
    } vm_state_e;

    localparam int unsigned SODA_COST = 8'd25;

endpackage

// File: rtl/fsm.sv
// Vending machine controller: sequences coin accumulation and dispense.
// Moore outputs drive the total register and the dispense strobe.
module fsm
    import vm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       c,
    input  logic       tot_lt_s,
    output logic       tot_ld,
    output logic       tot_clr,
    output logic       d,
    output logic [1:0] state_o
);

    vm_state_e state_q;
    vm_state_e state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // A coin in WAIT wins over a pending dispense decision.
    always_comb begin
        state_d = INIT;
        unique case (state_q)
            INIT: state_d = WAIT;
            WAIT: begin
                if (c) begin
                    state_d = ADD;
                end else if (!tot_lt_s) begin
                    state_d = DISP;
                end else begin
                    state_d = WAIT;
                end
            end
            ADD:     state_d = WAIT;
            DISP:    state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        tot_clr = 1'b0;
        tot_ld  = 1'b0;
        d       = 1'b0;
        unique case (state_q)
            INIT:    tot_clr = 1'b1;
            WAIT:    ;
            ADD:     tot_ld  = 1'b1;
            DISP:    d       = 1'b1;
            default: tot_clr = 1'b1;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the vending machine controller.
module tb_fsm;

    logic       clk;
    logic       rst_n;
    logic       c;
    logic       tot_lt_s;
    logic       tot_ld;
    logic       tot_clr;
    logic       d;
    logic [1:0] state;

    int n_chk;
    int n_pass;

    fsm u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .c        (c),
        .tot_lt_s (tot_lt_s),
        .tot_ld   (tot_ld),
        .tot_clr  (tot_clr),
        .d        (d),
        .state_o  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // outs packed as {tot_clr, tot_ld, d}
    task automatic expect_st(input string tag,
                             input logic [1:0] st,
                             input logic [2:0] outs);
        logic [2:0] o;
        o = {tot_clr, tot_ld, d};
        check({tag, ".state"}, {6'd0, state}, {6'd0, st});
        check({tag, ".outs"}, {5'd0, o}, {5'd0, outs});
        check({tag, ".excl"}, {7'd0, $onehot0(o)}, 8'd1);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        c        = 1'b0;
        tot_lt_s = 1'b1;

        #2;
        expect_st("rst_early", 2'd0, 3'b100);
        @(negedge clk);
        expect_st("rst_hold", 2'd0, 3'b100);
        rst_n = 1'b1;

        @(negedge clk);
        expect_st("first_wait", 2'd1, 3'b000);
        c = 1'b1;
        @(negedge clk);
        expect_st("coin_add", 2'd2, 3'b010);
        c = 1'b0;
        @(negedge clk);
        expect_st("coin_back", 2'd1, 3'b000);

        tot_lt_s = 1'b0;
        @(negedge clk);
        expect_st("disp", 2'd3, 3'b001);
        tot_lt_s = 1'b1;
        @(negedge clk);
        expect_st("disp_clr", 2'd0, 3'b100);
        @(negedge clk);
        expect_st("disp_wait", 2'd1, 3'b000);

        c        = 1'b1;
        tot_lt_s = 1'b0;
        @(negedge clk);
        expect_st("prio_add", 2'd2, 3'b010);
        c = 1'b0;
        @(negedge clk);
        expect_st("prio_wait", 2'd1, 3'b000);
        @(negedge clk);
        expect_st("prio_disp", 2'd3, 3'b001);
        tot_lt_s = 1'b1;

        #2;
        rst_n = 1'b0;
        #1;
        expect_st("async_rst", 2'd0, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_st("rst_wait", 2'd1, 3'b000);

        begin
            logic [1:0] st_tab [4];
            logic [2:0] o_tab  [4];
            st_tab = '{2'd2, 2'd1, 2'd2, 2'd1};
            o_tab  = '{3'b010, 3'b000, 3'b010, 3'b000};
            c = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 3) c = 1'b0;
                expect_st($sformatf("held%0d", i), st_tab[i], o_tab[i]);
            end
        end
        @(negedge clk);
        expect_st("held_idle", 2'd1, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
